// File: rtl/mul_arbiter.sv
// Two-port round-robin front end sharing one 16x16 unsigned multiplier.
// One operation in flight; result held until the owner takes it.
module wallace_mul (
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] r   [16];
  logic [31:0] nxt [16];
  logic [31:0] sum;
  int          n;
  int          m;

  // Carry-save reduction: 16 rows -> 11 -> 8 -> 6 -> 4 -> 3 -> 2
  always_comb begin
    for (int i = 0; i < 16; i++)
      r[i] = b[i] ? (32'(a) << i) : 32'd0;
    n = 16;
    for (int l = 0; l < 6; l++) begin
      m = 0;
      for (int k = 0; k < 16; k++)
        nxt[k] = '0;
      for (int g = 0; g < 5; g++) begin
        if (3 * g + 2 < n) begin
          nxt[4'(m)] = r[4'(3 * g)] ^ r[4'(3 * g + 1)]
                     ^ r[4'(3 * g + 2)];
          nxt[4'(m + 1)] =
            ((r[4'(3 * g)] & r[4'(3 * g + 1)])
           | (r[4'(3 * g)] & r[4'(3 * g + 2)])
           | (r[4'(3 * g + 1)] & r[4'(3 * g + 2)])) << 1;
          m = m + 2;
        end
      end
      for (int k = 0; k < 16; k++) begin
        if (k >= 3 * (n / 3) && k < n) begin
          nxt[4'(m)] = r[k];
          m = m + 1;
        end
      end
      for (int k = 0; k < 16; k++)
        r[k] = nxt[k];
      n = m;
    end
    sum = r[0] + r[1];
  end

  assign p = rst_n ? sum : 32'd0;

endmodule

module mul_arbiter #(
  parameter int CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_q,
  input  logic        resp0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_q,
  input  logic        resp1_ready,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        owner;
  logic        last;
  logic [31:0] result;
  logic [31:0] prod;
  logic        rst_n;
  logic        idle;
  logic        g0;
  logic        g1;
  logic        take;

  assign rst_n = ~rst;
  assign idle  = (state == IDLE);

  // Tie goes to whoever did not own the last completed operation
  assign g0 = req0_valid & (~req1_valid | last);
  assign g1 = req1_valid & (~req0_valid | ~last);

  assign req0_ready  = rst_n & idle & g0;
  assign req1_ready  = rst_n & idle & g1;
  assign resp0_valid = (state == RESP) & ~owner;
  assign resp1_valid = (state == RESP) & owner;
  assign resp0_q     = result;
  assign resp1_q     = result;
  assign busy        = ~idle;
  assign take        = owner ? resp1_ready : resp0_ready;

  wallace_mul u_mul (
    .rst_n (rst_n),
    .a     (op_a),
    .b     (op_b),
    .p     (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            op_a  <= req1_ready ? req1_a : req0_a;
            op_b  <= req1_ready ? req1_b : req0_b;
            owner <= req1_ready;
            cnt   <= CNT_INIT;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            result <= prod;
            state  <= RESP;
          end
        end
        RESP: begin
          if (take) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed and randomized checks for mul_arbiter.
// Main instance uses CALC_CYCLES=1, a second uses CALC_CYCLES=4.
module tb_mul_arbiter;

  logic        clk = 0;
  logic        rst = 1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        resp0_ready = 0, resp1_ready = 0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [31:0] resp0_q, resp1_q;

  logic        xv = 0, xr = 0;
  logic [15:0] xa = 0, xb = 0;
  logic        x_ready, x_rv, x_r1, x_rv1, x_busy;
  logic [31:0] x_q, x_q1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.CALC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .resp0_q(resp0_q), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp1_q(resp1_q), .resp1_ready(resp1_ready),
    .busy(busy)
  );

  mul_arbiter #(.CALC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(xv), .req0_a(xa), .req0_b(xb),
    .req0_ready(x_ready), .resp0_valid(x_rv),
    .resp0_q(x_q), .resp0_ready(xr),
    .req1_valid(1'b0), .req1_a(16'd0), .req1_b(16'd0),
    .req1_ready(x_r1), .resp1_valid(x_rv1),
    .resp1_q(x_q1), .resp1_ready(1'b0),
    .busy(x_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit p, input logic [15:0] a,
                    input logic [15:0] b, input logic [31:0] e,
                    input string tag);
    int k;
    if (!p) begin
      req0_valid = 1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b;
    end
    #1;
    k = 0;
    while (!(p ? req1_ready : req0_ready) && k < 50) begin
      tick; k++;
    end
    chk({tag, "_acc"}, 32'(k < 50), 1);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    k = 0;
    while (!(p ? resp1_valid : resp0_valid) && k < 50) begin
      tick; k++;
    end
    chk({tag, "_q"}, p ? resp1_q : resp0_q, e);
    resp0_ready = 1;
    resp1_ready = 1;
    tick;
    resp0_ready = 0;
    resp1_ready = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    #3;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int bad, both, spur, acc, done, cyc;
    logic pend0, pend1, a0, a1;
    logic [31:0] e0, e1;

    // Reset state, ready gated even with valid high
    req0_valid = 1;
    #12;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv0", resp0_valid, 0);
    chk("rst_q0", resp0_q, 0);
    req0_valid = 0;
    @(negedge clk);
    rst = 0;

    // Single request, first accept right after release
    req0_valid = 1; req0_a = 11451; req0_b = 250;
    #1;
    chk("single_ready", req0_ready, 1);
    tick;
    req0_valid = 0;
    chk("single_busy", busy, 1);
    chk("single_early", resp0_valid, 0);
    tick;
    chk("single_lat", resp0_valid, 1);
    chk("single_q", resp0_q, 2862750);
    chk("single_rv1", resp1_valid, 0);
    resp0_ready = 1;
    tick;
    resp0_ready = 0;
    chk("single_done", busy, 0);

    // Tie from reset and alternation
    do_reset;
    req0_valid = 1; req0_a = 1664; req0_b = 2615;
    req1_valid = 1; req1_a = 32000; req1_b = 11;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    chk("tie_r0", {req0_ready, req1_ready}, 2'b10);
    tick;
    tick;
    chk("tie_q0", resp0_valid ? resp0_q : 0, 4351360);
    tick;
    chk("alt_r1", {req0_ready, req1_ready}, 2'b01);
    tick;
    tick;
    chk("alt_q1", resp1_valid ? resp1_q : 0, 352000);
    tick;
    chk("alt_r0", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 0; req1_valid = 0;
    resp0_ready = 0; resp1_ready = 0;
    tick;

    // Backpressure on requester 1
    req1_valid = 1; req1_a = 520; req1_b = 1314;
    #1;
    tick;
    req1_valid = 0;
    req0_valid = 1; req0_a = 3; req0_b = 5;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!resp1_valid || req0_ready || resp0_valid) bad++;
      chk("bp_q", resp1_q, 683280);
    end
    chk("bp_hold", bad, 0);
    resp1_ready = 1;
    tick;
    resp1_ready = 0;
    chk("bp_release", req0_ready, 1);
    tick;
    req0_valid = 0;
    tick;
    chk("bp_next_q", resp0_valid ? resp0_q : 0, 15);
    resp0_ready = 1;
    tick;
    resp0_ready = 0;

    // Operand boundaries
    op(0, 16'd0, 16'd850, 32'd0, "zero");
    op(1, 16'd65535, 16'd65535, 32'd4294836225, "max");

    // Latency with CALC_CYCLES=4
    xv = 1; xa = 10086; xb = 12306;
    #1;
    chk("c4_ready", x_ready, 1);
    tick;
    xv = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("c4_lat", x_rv, 32'(i == 4));
    end
    chk("c4_q", x_q, 124118316);
    xr = 1;
    tick;
    xr = 0;

    // Reset during CALC aborts the operation
    req0_valid = 1; req0_a = 7; req0_b = 9;
    #1;
    tick;
    req0_valid = 0;
    rst = 1;
    #1;
    chk("abort_out",
        {busy, resp0_valid, resp1_valid, req0_ready, req1_ready}, 0);
    chk("abort_q", resp0_q | resp1_q, 0);
    @(negedge clk);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (resp0_valid || resp1_valid || busy) bad++;
    end
    chk("abort_quiet", bad, 0);
    op(0, 16'd123, 16'd456, 32'd56088, "after_abort");

    // Random traffic on both ports
    both = 0; spur = 0; acc = 0; done = 0; cyc = 0;
    pend0 = 0; pend1 = 0; e0 = 0; e1 = 0;
    while ((done < 1000 || pend0 || pend1) && cyc < 30000) begin
      if (!req0_valid && done < 1000) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = 16'($urandom); req0_b = 16'($urandom);
      end
      if (!req1_valid && done < 1000) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = 16'($urandom); req1_b = 16'($urandom);
      end
      resp0_ready = 1'($urandom_range(0, 1));
      resp1_ready = 1'($urandom_range(0, 1));
      #1;
      if (req0_ready && req1_ready) both++;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) begin
        if (pend0) spur++;
        pend0 = 1; acc++;
        e0 = 32'(req0_a) * 32'(req0_b);
      end
      if (a1) begin
        if (pend1) spur++;
        pend1 = 1; acc++;
        e1 = 32'(req1_a) * 32'(req1_b);
      end
      if (resp0_valid && resp0_ready) begin
        if (!pend0) spur++;
        else chk("rnd_q0", resp0_q, e0);
        pend0 = 0; done++;
      end
      if (resp1_valid && resp1_ready) begin
        if (!pend1) spur++;
        else chk("rnd_q1", resp1_q, e1);
        pend1 = 0; done++;
      end
      @(posedge clk);
      #1;
      if (a0) req0_valid = 0;
      if (a1) req1_valid = 0;
      cyc++;
    end
    chk("rnd_budget", 32'(cyc < 30000), 1);
    chk("rnd_count", acc, done);
    chk("rnd_two_ready", both, 0);
    chk("rnd_spurious", spur, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
